present_core: RTL and testbench
===============================

// Module: present_core
// PURPOSE
//   Iterative PRESENT block-cipher encryption engine. It is the parametrised
//   successor of the single-round datapath: it supports 80- or 128-bit keys,
//   sequences all rounds internally and adds a start/busy/done handshake.
//   Inputs are plaintext and key; output is a registered ciphertext. It sits
//   between the host-side loader and the result capture register.
// PARAMETERS
//   KEY_WIDTH  80  key length; legal values 80 or 128 (elaboration error otherwise)
//   ROUNDS     31  number of sBox/pLayer rounds, 1..31; 31 = standard PRESENT
// PORTS
//   clk         in   1          rising-edge clock
//   rst         in   1          synchronous reset, active-high
//   start       in   1          request; sampled only in IDLE
//   plaintext   in   64         block to encrypt; captured when start is accepted
//   key         in   KEY_WIDTH  cipher key; captured when start is accepted
//   busy        out  1          high from the cycle after acceptance until done
//   done        out  1          one-cycle pulse; ciphertext is valid
//   ciphertext  out  64         result; held until the next completion
// BEHAVIOUR
//   Reset: state=IDLE, busy=0, done=0, ciphertext=0; state/key/round registers=0.
//     rst mid-operation aborts the operation; no done is issued.
//   FSM: IDLE -> RUN -> FINAL -> IDLE.
//   IDLE: if start, then S<=plaintext, K<=key, rc<=1, busy<=1, go to RUN.
//     Otherwise hold.
//   RUN, one round per clk:
//     S <= P(Sbox(S ^ K[KW-1:KW-64])); K <= keyupd(K, rc); rc <= rc+1.
//     When rc==ROUNDS, go to FINAL.
//   FINAL: ciphertext <= S ^ K[KW-1:KW-64]; done<=1 (one cycle); busy<=0; go to IDLE.
//   Latency: start sampled at edge E0. Rounds run at E1..E(ROUNDS).
//     done is high during the cycle after edge E(ROUNDS+1): 33 edges for ROUNDS=31.
//   Sbox (nibble-wise, input 0..F): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
//   P layer: bit i moves to bit (16*i) mod 63 for i<63; bit 63 stays in place.
//   Key update for KW=80:
//     K <= K<<<61; then K[79:76] <= Sbox(K[79:76]); then K[19:15] ^= rc[4:0].
//   Key update for KW=128:
//     K <= K<<<61; then K[127:124] and K[123:120] go through Sbox;
//     then K[66:62] ^= rc[4:0].
//   rc is 5 bits and counts 1..ROUNDS; it never wraps within an operation.
//   start while busy or in FINAL: ignored, not queued.
//   start in the same cycle that done is high: the FSM is already in IDLE,
//     so the start is accepted and the new operation begins.
//   plaintext/key changes after acceptance: no effect on the running operation.
//   busy and done are never high in the same cycle.
// TESTING
//   1. KW=80, pt=0, key=0, start 1 cycle -> done after 33 edges,
//      ciphertext=64'h5579C1387B228445.
//   2. KW=80, pt=0, key=80'hFFFF_FFFF_FFFF_FFFF_FFFF -> ciphertext=64'hE72C46C0F5945049.
//      pt=64'hFFFF_FFFF_FFFF_FFFF, key=0 -> ciphertext=64'hA112FFC72F68417B.
//      pt=all-F, key=all-F -> ciphertext=64'h3333DCD3213210D2.
//   3. KW=128, pt=0, key=0 -> ciphertext=64'h96DB702A2E6900AF.
//   4. Pulse start again at round 10, changing pt and key -> the result is
//      unchanged (case 1 value) and exactly one done pulse is issued.
//   5. Assert rst at round 15 -> busy=0, done=0, ciphertext=0 the next cycle.
//      A new start then gives the correct result.
//   6. Hold start high continuously -> back-to-back operations, done every
//      33 cycles, busy low only in done cycles; ciphertext stable between done pulses.

Source files
------------

// File: rtl/present_core.sv
// -----------------------------------------------------------------------------
// present_core
//   Iterative PRESENT block-cipher encryption engine for 80- or 128-bit keys.
//   A start request in IDLE captures the plaintext and key. The engine then
//   runs one sBox/pLayer round per clock for ROUNDS rounds. A final key
//   whitening step produces the registered ciphertext and a one-cycle done.
//
// Parameters
//   KEY_WIDTH  key length, 80 or 128
//   ROUNDS     number of rounds, 1..31 (31 = standard PRESENT)
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high
//   start       in   request, sampled only in IDLE
//   plaintext   in   64-bit block, captured when start is accepted
//   key         in   KEY_WIDTH-bit key, captured when start is accepted
//   busy        out  high from the cycle after acceptance until done
//   done        out  one-cycle pulse, ciphertext valid
//   ciphertext  out  64-bit result, held until the next completion
// -----------------------------------------------------------------------------
module present_core #(
    parameter int KEY_WIDTH = 80,
    parameter int ROUNDS    = 31
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [63:0]          plaintext,
    input  logic [KEY_WIDTH-1:0] key,
    output logic                 busy,
    output logic                 done,
    output logic [63:0]          ciphertext
);

    if (KEY_WIDTH != 80 && KEY_WIDTH != 128) begin : g_bad_key_width
        $error("present_core: KEY_WIDTH must be 80 or 128");
    end

    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
        $error("present_core: ROUNDS must be in 1..31");
    end

    localparam logic [4:0] LAST_RC = ROUNDS[4:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FINAL = 2'd2
    } state_t;

    state_t               r_fsm;
    logic [63:0]          r_state;
    logic [KEY_WIDTH-1:0] r_key;
    logic [4:0]           r_rc;
    logic                 r_busy;
    logic                 r_done;
    logic [63:0]          r_ct;

    logic [63:0]          w_round_key;
    logic [63:0]          w_state_next;
    logic [KEY_WIDTH-1:0] w_key_rot;
    logic [KEY_WIDTH-1:0] w_key_next;

    // 4-bit PRESENT substitution box
    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int n = 0; n < 16; n++) begin
            y[4*n +: 4] = sbox4(x[4*n +: 4]);
        end
        return y;
    endfunction

    // Bit i lands on bit (16*i) mod 63; bit 63 is a fixed point
    function automatic logic [63:0] p_layer(input logic [63:0] x);
        logic [63:0] y;
        y = '0;
        for (int i = 0; i < 63; i++) begin
            y[(16*i) % 63] = x[i];
        end
        y[63] = x[63];
        return y;
    endfunction

    // Round key is always the top 64 bits of the key register
    assign w_round_key  = r_key[KEY_WIDTH-1 -: 64];
    assign w_state_next = p_layer(sbox_layer(r_state ^ w_round_key));

    // Rotate left by 61
    assign w_key_rot = {r_key[KEY_WIDTH-62:0], r_key[KEY_WIDTH-1 -: 61]};

    if (KEY_WIDTH == 128) begin : g_key128
        always_comb begin
            w_key_next          = w_key_rot;
            w_key_next[127:124] = sbox4(w_key_rot[127:124]);
            w_key_next[123:120] = sbox4(w_key_rot[123:120]);
            w_key_next[66:62]   = w_key_rot[66:62] ^ r_rc;
        end
    end else begin : g_key80
        always_comb begin
            w_key_next                          = w_key_rot;
            w_key_next[KEY_WIDTH-1 -: 4]        = sbox4(w_key_rot[KEY_WIDTH-1 -: 4]);
            w_key_next[19:15]                   = w_key_rot[19:15] ^ r_rc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm   <= S_IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_rc    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ct    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (start) begin
                        r_state <= plaintext;
                        r_key   <= key;
                        r_rc    <= 5'd1;
                        r_busy  <= 1'b1;
                        r_fsm   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_state <= w_state_next;
                    r_key   <= w_key_next;
                    // rc stops at its last value rather than wrapping
                    if (r_rc == LAST_RC) begin
                        r_fsm <= S_FINAL;
                    end else begin
                        r_rc <= r_rc + 5'd1;
                    end
                end
                S_FINAL: begin
                    r_ct   <= r_state ^ w_round_key;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                    r_fsm  <= S_IDLE;
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign ciphertext = r_ct;

endmodule

// File: tb/tb_present_core.sv
module tb_present_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         start80, start128;
    logic [63:0]  pt80, pt128;
    logic [79:0]  key80;
    logic [127:0] key128;
    logic         busy80, done80, busy128, done128;
    logic [63:0]  ct80, ct128;

    present_core #(.KEY_WIDTH(80), .ROUNDS(31)) dut80 (
        .clk(clk), .rst(rst), .start(start80), .plaintext(pt80), .key(key80),
        .busy(busy80), .done(done80), .ciphertext(ct80)
    );

    present_core #(.KEY_WIDTH(128), .ROUNDS(31)) dut128 (
        .clk(clk), .rst(rst), .start(start128), .plaintext(pt128), .key(key128),
        .busy(busy128), .done(done128), .ciphertext(ct128)
    );

    typedef struct {
        logic [63:0] ct;
        int          cyc;
    } exp_t;

    exp_t        q80[$];
    exp_t        q128[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;
    int          done_cnt[2];
    logic [63:0] hold[2];
    bit          mon_en = 1'b0;
    bit          b2b    = 1'b0;

    logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                           4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

    always @(posedge clk) cyc <= cyc + 1;

    // Reference PRESENT encryption over a kw-bit key held in the low bits
    function automatic logic [63:0] ref_present(input logic [63:0] pt,
                                                input logic [127:0] k_in,
                                                input int kw);
        logic [127:0] k, nk;
        logic [63:0]  s, t, p;
        int           lo;
        k  = k_in;
        s  = pt;
        lo = (kw == 80) ? 15 : 62;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ 64'(k >> (kw - 64));
            for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[s[4*n +: 4]];
            for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (16*i) % 63] = t[i];
            nk = '0;
            for (int j = 0; j < kw; j++) nk[(j + 61) % kw] = k[j];
            k = nk;
            k[kw-1 -: 4] = SB[k[kw-1 -: 4]];
            if (kw == 128) k[kw-5 -: 4] = SB[k[kw-5 -: 4]];
            k[lo +: 5] = k[lo +: 5] ^ 5'(r);
            s = p;
        end
        return s ^ 64'(k >> (kw - 64));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic mon_step(input int id, input logic d, input logic b, input logic [63:0] ct);
        exp_t e;
        check($sformatf("busy_done_exclusive%0d", id), {63'd0, b & d}, 64'd0);
        if (rst) begin
            hold[id] = '0;
            return;
        end
        if (d) begin
            done_cnt[id]++;
            if ((id == 0 && q80.size() == 0) || (id == 1 && q128.size() == 0)) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done%0d: got done at cycle %0d, required none", id, cyc);
            end else begin
                if (id == 0) e = q80.pop_front();
                else         e = q128.pop_front();
                check($sformatf("ciphertext%0d", id), ct, e.ct);
                check($sformatf("done_cycle%0d", id), 64'(cyc), 64'(e.cyc));
            end
            hold[id] = ct;
        end else begin
            check($sformatf("ct_stable%0d", id), ct, hold[id]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(0, done80, busy80, ct80);
            mon_step(1, done128, busy128, ct128);
            if (b2b) check("b2b_busy_not_done", {63'd0, busy80}, {63'd0, ~done80});
        end
    end

    task automatic push_exp(input int id, input logic [63:0] exp_ct);
        exp_t e;
        e.ct  = exp_ct;
        e.cyc = cyc + 32;
        if (id == 0) q80.push_back(e);
        else         q128.push_back(e);
    endtask

    // Called shortly after a rising edge with the target engine idle
    task automatic launch(input int id, input logic [63:0] pt, input logic [127:0] k,
                          input logic [63:0] exp_ct);
        if (id == 0) begin pt80 = pt; key80 = k[79:0]; start80 = 1'b1; end
        else         begin pt128 = pt; key128 = k; start128 = 1'b1; end
        @(posedge clk); #1;
        push_exp(id, exp_ct);
        start80  = 1'b0;
        start128 = 1'b0;
    endtask

    task automatic wait_done(input int id, input int target, input int budget);
        int n = 0;
        while (done_cnt[id] < target && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        tests++;
        if (done_cnt[id] < target) begin
            fails++;
            $display("FAIL timeout%0d: got %0d done pulses, required %0d", id, done_cnt[id], target);
        end
    endtask

    task automatic run_one(input int id, input logic [63:0] pt, input logic [127:0] k,
                           input logic [63:0] exp_ct);
        int t = done_cnt[id] + 1;
        launch(id, pt, k, exp_ct);
        wait_done(id, t, 60);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]  pt;
        logic [127:0] k;
        int           c0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        hold[0] = '0; hold[1] = '0;
        rst = 1'b1; start80 = 1'b0; start128 = 1'b0;
        pt80 = '0; pt128 = '0; key80 = '0; key128 = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_busy80", {63'd0, busy80}, 64'd0);
        check("rst_done80", {63'd0, done80}, 64'd0);
        check("rst_ct80", ct80, 64'd0);
        check("rst_busy128", {63'd0, busy128}, 64'd0);
        check("rst_done128", {63'd0, done128}, 64'd0);
        check("rst_ct128", ct128, 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // Known-answer vectors
        run_one(0, 64'h0, 128'h0, 64'h5579C1387B228445);
        run_one(0, 64'h0, {48'd0, {80{1'b1}}}, 64'hE72C46C0F5945049);
        run_one(0, {64{1'b1}}, 128'h0, 64'hA112FFC72F68417B);
        run_one(0, {64{1'b1}}, {48'd0, {80{1'b1}}}, 64'h3333DCD3213210D2);
        run_one(1, 64'h0, 128'h0, 64'h96DB702A2E6900AF);

        // Random blocks and keys against the reference model
        for (int i = 0; i < 4; i++) begin
            pt = {$urandom, $urandom};
            k  = {48'd0, 80'({$urandom, $urandom, $urandom})};
            run_one(0, pt, k, ref_present(pt, k, 80));
            pt = {$urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            run_one(1, pt, k, ref_present(pt, k, 128));
        end

        // Start pulse during round 10 with new inputs is ignored
        c0 = done_cnt[0];
        launch(0, 64'h0, 128'h0, 64'h5579C1387B228445);
        repeat (9) @(posedge clk); #1;
        pt80 = {$urandom, $urandom};
        key80 = 80'({$urandom, $urandom, $urandom});
        start80 = 1'b1;
        @(posedge clk); #1;
        start80 = 1'b0;
        wait_done(0, c0 + 1, 60);
        repeat (40) @(posedge clk); #1;
        check("single_done", 64'(done_cnt[0]), 64'(c0 + 1));

        // Reset at round 15 aborts the operation
        pt = {$urandom, $urandom};
        k  = {48'd0, 80'({$urandom, $urandom, $urandom})};
        launch(0, pt, k, ref_present(pt, k, 80));
        repeat (14) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {63'd0, busy80}, 64'd0);
        check("abort_done", {63'd0, done80}, 64'd0);
        check("abort_ct", ct80, 64'd0);
        q80.delete();
        rst = 1'b0;
        pt = {$urandom, $urandom};
        k  = {48'd0, 80'({$urandom, $urandom, $urandom})};
        run_one(0, pt, k, ref_present(pt, k, 80));

        // Start held high: back-to-back operations every 33 cycles
        c0 = done_cnt[0];
        pt80 = {$urandom, $urandom};
        key80 = 80'({$urandom, $urandom, $urandom});
        start80 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (n == 0) @(posedge clk);
            else        repeat (33) @(posedge clk);
            #1;
            push_exp(0, ref_present(pt80, {48'd0, key80}, 80));
            if (n == 0) b2b = 1'b1;
            pt80 = {$urandom, $urandom};
            key80 = 80'({$urandom, $urandom, $urandom});
        end
        start80 = 1'b0;
        wait_done(0, c0 + 4, 200);
        b2b = 1'b0;

        repeat (5) @(posedge clk); #1;
        check("queue80_empty", 64'(q80.size()), 64'd0);
        check("queue128_empty", 64'(q128.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
